// File: rtl/vga_clock_divider_param_pkg.sv
// -----------------------------------------------------------------------------
// vga_clkdiv_pkg
// Shared constants for the parametrised VGA clock divider.
//   CNT_W_DEFAULT : default width of the counter and divisor
//   DIV_MIN       : smallest legal divisor (a divisor of 0 is rejected on load)
// The divisor type itself (div_t) depends on the CNT_W parameter of each
// module, so it is declared locally inside the modules that need it.
// -----------------------------------------------------------------------------
package vga_clkdiv_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int DIV_MIN       = 1;

endpackage : vga_clkdiv_pkg

// File: rtl/vga_clock_divider_param_if.sv
// -----------------------------------------------------------------------------
// vga_clock_divider_param_if
// Control and output bundle of the parametrised VGA clock divider.
//   en        : count enable
//   div_in    : requested divisor
//   div_load  : one-cycle request to load div_in
//   div_busy  : a loaded divisor waits for the next wrap
//   div_err   : one-cycle pulse, a load of 0 was rejected
//   tick      : one-cycle strobe at the start of each period
//   clkout    : registered divided clock
//   count     : current counter value
//   clkout90  : quadrature clock (only with VGA_CLKDIV_QUAD_EN defined)
// Modports: master (controller / consumer side), slave (divider side).
// -----------------------------------------------------------------------------
interface vga_clock_divider_param_if #(
  parameter int CNT_W = 8
) ();

  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             div_busy;
  logic             div_err;
  logic             tick;
  logic             clkout;
  logic [CNT_W-1:0] count;
`ifdef VGA_CLKDIV_QUAD_EN
  logic             clkout90;
`endif

  modport master (
    output en,
    output div_in,
    output div_load,
    input  div_busy,
    input  div_err,
    input  tick,
    input  clkout,
`ifdef VGA_CLKDIV_QUAD_EN
    input  clkout90,
`endif
    input  count
  );

  modport slave (
    input  en,
    input  div_in,
    input  div_load,
    output div_busy,
    output div_err,
    output tick,
    output clkout,
`ifdef VGA_CLKDIV_QUAD_EN
    output clkout90,
`endif
    output count
  );

endinterface : vga_clock_divider_param_if

// File: rtl/vga_clock_divider_param_core.sv
// -----------------------------------------------------------------------------
// clkdiv_core
// Counter, wrap detection and the registered tick/clkout outputs.
//   clk            : master clock, rising edge
//   reset          : synchronous active-high reset
//   en_i           : count enable
//   div_active_i   : divisor of the period currently running
//   div_next_i     : divisor that will be active in the next cycle
//   wrap_o         : combinational, this enabled cycle is the last of a period
//   count_next_o   : combinational next counter value
//   count_o        : registered counter
//   tick_o         : registered period-start strobe
//   clkout_o       : registered divided clock
// clkout is computed from the next count and the next divisor so that the
// registered value always matches (count >= div_active>>1) in the same cycle,
// including the first cycle after a divisor change.
// -----------------------------------------------------------------------------
module clkdiv_core
  import vga_clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_active_i,
  input  logic [CNT_W-1:0] div_next_i,
  output logic             wrap_o,
  output logic [CNT_W-1:0] count_next_o,
  output logic [CNT_W-1:0] count_o,
  output logic             tick_o,
  output logic             clkout_o
);

  typedef logic [CNT_W-1:0] div_t;

  localparam div_t ZERO = {CNT_W{1'b0}};
  localparam div_t ONE  = div_t'(DIV_MIN);

  div_t count_q;
  div_t count_d;
  logic tick_q;
  logic tick_d;
  logic clkout_q;
  logic clkout_d;
  logic wrap_s;

  // Next-state logic for the counter, tick and divided clock.
  always_comb begin
    count_d  = count_q;
    wrap_s   = en_i && (count_q == (div_active_i - ONE));
    if (wrap_s) begin
      count_d = ZERO;
    end else if (en_i) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
    // tick marks the first cycle of the new period; never set when idle
    tick_d   = wrap_s;
    clkout_d = (count_d >= (div_next_i >> 1));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= ZERO;
      tick_q   <= 1'b0;
      clkout_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      tick_q   <= tick_d;
      clkout_q <= clkout_d;
    end
  end

  assign wrap_o       = wrap_s;
  assign count_next_o = count_d;
  assign count_o      = count_q;
  assign tick_o       = tick_q;
  assign clkout_o     = clkout_q;

endmodule : clkdiv_core

// File: rtl/vga_clock_divider_param.sv
// -----------------------------------------------------------------------------
// vga_clock_divider_param
// Runtime-programmable clock divider for the VGA timing/pixel logic.
// Produces a registered divided clock and a one-cycle tick per period.
//   clkin  : master clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : vga_clock_divider_param_if.slave (en, div_in, div_load in;
//            div_busy, div_err, tick, clkout, count [, clkout90] out)
// Parameters: CNT_W (counter/divisor width), DIV_DEFAULT (divisor after reset,
// legal 1..2^CNT_W-1).
// Optional feature macro: VGA_CLKDIV_QUAD_EN adds the quadrature clock
// clkout90 = (((count + (div>>2)) mod div) >= div>>1).
// A new divisor is only applied on a wrap cycle, so a period is never cut
// short or stretched by a load.
// -----------------------------------------------------------------------------
module vga_clock_divider_param
  import vga_clkdiv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DIV_DEFAULT = 4
) (
  input  logic                       clkin,
  input  logic                       reset,
  vga_clock_divider_param_if.slave   bus
);

  typedef logic [CNT_W-1:0] div_t;

  localparam div_t ZERO    = {CNT_W{1'b0}};
  localparam div_t DIV_RST = div_t'(DIV_DEFAULT);

  div_t div_active_q;
  div_t div_active_d;
  div_t pending_q;
  div_t pending_d;
  logic busy_q;
  logic busy_d;
  logic err_q;
  logic err_d;

  logic wrap_s;
  logic load_ok_s;
  logic load_zero_s;
  div_t count_next_s;
  div_t count_s;
  logic tick_s;
  logic clkout_s;

  clkdiv_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk          (clkin),
    .reset        (reset),
    .en_i         (bus.en),
    .div_active_i (div_active_q),
    .div_next_i   (div_active_d),
    .wrap_o       (wrap_s),
    .count_next_o (count_next_s),
    .count_o      (count_s),
    .tick_o       (tick_s),
    .clkout_o     (clkout_s)
  );

  // Load handshake: reject zero, otherwise pend until the next wrap.
  always_comb begin
    load_zero_s  = bus.div_load && (bus.div_in == ZERO);
    load_ok_s    = bus.div_load && (bus.div_in != ZERO);
    div_active_d = div_active_q;
    pending_d    = pending_q;
    busy_d       = busy_q;
    err_d        = load_zero_s;
    if (load_ok_s) begin
      if (wrap_s) begin
        // load on the wrap cycle itself goes straight in; overrides any pending
        div_active_d = bus.div_in;
        busy_d       = 1'b0;
      end else begin
        pending_d    = bus.div_in;
        busy_d       = 1'b1;
      end
    end else if (wrap_s && busy_q) begin
      div_active_d = pending_q;
      busy_d       = 1'b0;
    end else begin
      busy_d       = busy_q;
    end
  end

  // Divisor, pending and handshake registers with synchronous reset.
  always_ff @(posedge clkin) begin
    if (reset) begin
      div_active_q <= DIV_RST;
      pending_q    <= ZERO;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      div_active_q <= div_active_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

`ifdef VGA_CLKDIV_QUAD_EN
  logic clkout90_q;
  logic clkout90_d;

  // Quadrature level for a given count/divisor; count < div so the sum is
  // below 2*div and one conditional subtract implements the modulo.
  function automatic logic quad_level(input div_t cnt, input div_t div);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, (div >> 2)};
    if (sum >= {1'b0, div}) begin
      sum = sum - {1'b0, div};
    end else begin
      sum = sum;
    end
    return (sum >= {1'b0, (div >> 1)});
  endfunction

  // Next quadrature level, from the same next count/divisor as clkout.
  always_comb begin
    clkout90_d = quad_level(count_next_s, div_active_d);
  end

  // Quadrature clock register with synchronous reset.
  always_ff @(posedge clkin) begin
    if (reset) begin
      clkout90_q <= 1'b0;
    end else begin
      clkout90_q <= clkout90_d;
    end
  end

  assign bus.clkout90 = clkout90_q;
`else
  // next count is only needed by the quadrature option
  logic unused_s;
  assign unused_s = ^count_next_s;
`endif

  assign bus.div_busy = busy_q;
  assign bus.div_err  = err_q;
  assign bus.tick     = tick_s;
  assign bus.clkout   = clkout_s;
  assign bus.count    = count_s;

endmodule : vga_clock_divider_param

// File: doc/vga_clock_divider_param.md
Name: vga_clock_divider_param

Overview:
- Parametrised successor of the fixed divide-by-4 VGA clock divider.
- Produces a registered divided clock (`clkout`) and a one-cycle clock-enable strobe (`tick`) from the master clock.
- Divide ratio is runtime-programmable, with glitch-free updates at period boundaries.
- Sits between the 100 MHz master clock and the VGA timing/pixel logic; other timing consumers can reuse it for arbitrary rates.

Parameters:
- CNT_W, 8, width of the counter and divisor.
- DIV_DEFAULT, 4, divisor after reset. Legal range 1..2^CNT_W-1; the default gives 25 MHz from 100 MHz.

Ports:
- clkin  in  1  master clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; counter advances only when high.
- div_in  in  CNT_W  requested divisor.
- div_load  in  1  one-cycle request to load div_in.
- div_busy  out  1  a loaded divisor is pending, waiting for the next wrap.
- div_err  out  1  one-cycle pulse: a load was rejected (div_in==0).
- tick  out  1  one-cycle strobe at the start of each period.
- clkout  out  1  registered divided clock.
- count  out  CNT_W  current counter value.

Behaviour:
- Reset is synchronous, active-high. It applies in any state, including mid-load: counter 0, active divisor DIV_DEFAULT, pending cleared, div_busy 0, div_err 0, tick 0, clkout 0.
- Counting, on each cycle with en=1:
  - wrap cycle (count == div_active-1): count <= 0;
  - otherwise count <= count+1.
- en=0: count, clkout and div_busy hold; tick forced 0.
- tick is registered. It is 1 exactly in the cycle where count==0 following a wrap, and never immediately after reset.
- clkout is registered and always equals (count >= div_active>>1):
  - DIV=4 gives low on counts 0,1 and high on 2,3 (identical to the legacy divider).
  - Odd DIV=5 gives 2 cycles low, 3 cycles high.
  - DIV=1 gives clkout constantly 1 and tick every enabled cycle.
- Load handshake, for div_load=1:
  - div_in==0: rejected, div_err=1 next cycle, pending state unchanged.
  - Otherwise div_in is captured into pending and div_busy=1 next cycle.
- Applying a pending divisor:
  - At the next wrap cycle (en=1), div_active <= pending and div_busy <= 0; the new period starts at count 0.
  - A load arriving while div_busy=1 overwrites pending (last wins).
  - A load coinciding with a wrap cycle takes effect at that wrap; div_busy stays 0.
- No partial periods: the divisor never changes mid-period, so clkout and tick never glitch or shorten.
- Arithmetic is unsigned CNT_W-bit. div_active-1 never underflows because div_active>=1 is guaranteed.

Optional Feature:
- Macro: VGA_CLKDIV_QUAD_EN.
- Defined:
  - Adds output clkout90 (out, 1), a registered quadrature clock equal to (((count + (div_active>>2)) mod div_active) >= div_active>>1).
  - Reset value 0; holds when en=0; follows divisor changes at the same wrap.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package vga_clkdiv_pkg:
  - localparam CNT_W_DEFAULT=8, DIV_MIN=1;
  - typedef logic [CNT_W-1:0] div_t (parametrised via the module).
- Natural sub-module clkdiv_core: counter, wrap detect, tick/clkout registers; inputs en and div_active.
- Top level owns the pending register, div_busy/div_err handshake and the quad option.

Test Plan:
- Reset, en=1, no loads → clkout period 4 cycles (2 low/2 high), tick every 4th cycle starting 4 cycles after reset release.
- Load div_in=5 at count=1 → div_busy=1 until the wrap, then period 5 with clkout 2 low/3 high; no short period observed.
- Loads 6 then 8 on consecutive cycles while busy → only 8 applied at the wrap, div_busy drops the same cycle.
- Load div_in=0 → div_err pulses 1 cycle, div_busy stays 0, period unchanged at 4.
- en toggled low for 3 cycles mid-period → count/clkout frozen, tick 0; resumes without losing a count. Reset asserted with load pending → all outputs to reset values, pending discarded.
- VGA_CLKDIV_QUAD_EN defined, DIV=8 → clkout90 leads clkout by 2 cycles and has period 8; DIV=1 → tick every cycle, clkout held 1.
